// File: rtl/pc_redirect_controller_pkg.sv
// Core-wide definitions shared by the fetch-PC sequencer and its helpers.
package pc_redirect_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam int PC_INC      = 4;
    localparam int TAKEN_CNT_W = 16;

endpackage

// File: rtl/pc_redirect_controller_sat_counter.sv
// Saturating up-counter; sticks at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (inc && (r_count != '1))
            r_count <= r_count + WIDTH'(1);
    end

    assign count = r_count;

endmodule

// File: rtl/pc_redirect_controller.sv
// Fetch PC owner: sequences the PC from EX-stage branch resolution, flushes
// younger stages on redirect, drains into a parked state on halt.
module pc_redirect_controller
    import pc_redirect_controller_pkg::*;
#(
    parameter int          PC_WIDTH     = 9,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   fetch_en,
    output logic                   flush_ifid,
    output logic                   flush_idex,
    output logic                   halted,
    output logic                   misalign_err,
    output logic [TAKEN_CNT_W-1:0] taken_count
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    pc_state_e           r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [3:0]          r_drain_cnt;
    logic                r_misalign;

    logic                w_run;
    logic                w_misalign_redir;
    logic                w_taken_inc;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_unused_tgt;

    assign w_run            = (r_state == ST_RUN);
    assign w_misalign_redir = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign w_target         = redirect_target[PC_WIDTH-1:0];
    // Upper target bits are outside the instruction memory and deliberately dropped.
    assign w_unused_tgt     = ^redirect_target[31:PC_WIDTH];

    // Only a plain aligned redirect counts; trap and halt both preempt it.
    assign w_taken_inc = w_run && redirect_valid && !w_misalign_redir && !halt_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC[PC_WIDTH-1:0];
            r_drain_cnt <= '0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_misalign_redir) begin
                        r_misalign  <= 1'b1;
                        r_drain_cnt <= DRAIN_INIT;
                        r_state     <= ST_DRAIN;
                    end else if (halt_req) begin
                        r_pc        <= w_target;
                        r_drain_cnt <= DRAIN_INIT;
                        r_state     <= ST_DRAIN;
                    end else if (redirect_valid) begin
                        r_pc <= w_target;
                    end else if (!stall) begin
                        r_pc <= r_pc + PC_WIDTH'(PC_INC);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0)
                        r_state <= ST_HALTED;
                    else
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                end
                ST_HALTED: begin
                    // A misalignment trap is only cleared by reset.
                    if (resume && !r_misalign)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(TAKEN_CNT_W)) u_taken_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_taken_inc),
        .count   (taken_count)
    );

    assign pc           = r_pc;
    assign fetch_en     = w_run && !stall;
    assign flush_ifid   = w_run && (redirect_valid || halt_req);
    assign flush_idex   = w_run && (redirect_valid || halt_req);
    assign halted       = (r_state == ST_HALTED);
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Scoreboard bench for pc_redirect_controller: a reference model pushes the
// expected outputs per cycle and the sampler pops and compares them.
module tb_pc_redirect_controller;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic [8:0]  pc;
    logic        fetch_en;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halted;
    logic        misalign_err;
    logic [15:0] taken_count;

    pc_redirect_controller #(
        .PC_WIDTH     (9),
        .RESET_PC     (32'h0),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc              (pc),
        .fetch_en        (fetch_en),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .taken_count     (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  pc;
        logic        fe;
        logic        fl;
        logic        hl;
        logic        me;
        logic [15:0] tc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: 0 RUN, 1 DRAIN, 2 HALTED
    int          m_st;
    logic [8:0]  m_pc;
    int          m_cnt;
    logic        m_mis;
    logic [15:0] m_tc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pc  = 9'h0;
        m_cnt = 0;
        m_mis = 1'b0;
        m_tc  = 16'h0;
    endtask

    // Called at posedge+1: drive, push expectation, compare at negedge, advance model.
    task automatic step(input logic st, input logic rv, input logic hr,
                        input logic rs, input logic [31:0] tg);
        exp_t e, o;
        stall = st; redirect_valid = rv; halt_req = hr; resume = rs; redirect_target = tg;
        e.pc = m_pc;
        e.fe = (m_st == 0) && !st;
        e.fl = (m_st == 0) && (rv || hr);
        e.hl = (m_st == 2);
        e.me = m_mis;
        e.tc = m_tc;
        sb_q.push_back(e);
        @(negedge clk);
        o = sb_q.pop_front();
        chk("pc",       32'(pc),           32'(o.pc));
        chk("fetch_en", 32'(fetch_en),     32'(o.fe));
        chk("flush_if", 32'(flush_ifid),   32'(o.fl));
        chk("flush_ix", 32'(flush_idex),   32'(o.fl));
        chk("halted",   32'(halted),       32'(o.hl));
        chk("misalign", 32'(misalign_err), 32'(o.me));
        chk("taken",    32'(taken_count),  32'(o.tc));
        case (m_st)
            0: begin
                if (rv && tg[1:0] != 2'b00) begin
                    m_mis = 1'b1; m_cnt = 1; m_st = 1;
                end else if (hr) begin
                    m_pc = tg[8:0]; m_cnt = 1; m_st = 1;
                end else if (rv) begin
                    m_pc = tg[8:0];
                    if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
                end else if (!st) begin
                    m_pc = m_pc + 9'd4;
                end
            end
            1: if (m_cnt == 0) m_st = 2; else m_cnt = m_cnt - 1;
            default: if (rs && !m_mis) m_st = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases after the edge.
    task automatic do_reset();
        stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        redirect_target = 32'h0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_pc",       32'(pc),           32'h0);
        chk("rst_halted",   32'(halted),       32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        chk("rst_taken",    32'(taken_count),  32'h0);
        chk("rst_fetch_en", 32'(fetch_en),     32'h1);
        chk("rst_flush",    32'(flush_ifid),   32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        redirect_target = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Free run 0,4,8,12 then redirect from 0x010
        idle(4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
        idle(1);
        // Redirect beats stall, then stall alone
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        // Halt, drain, park, resume
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0024);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle(2);
        // Resume outside HALTED has no effect
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        // Misaligned redirect traps; resume ignored; reset clears
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0106);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        do_reset();
        idle(1);
        // Wrap and upper-bit truncation
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_01FC);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_F008);
        idle(1);
        // Simultaneous halt and redirect: halt wins, no count
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0030);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        idle(1);

        // Random aligned traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0),
                 $urandom & 32'hFFFF_FFFC);
        end
        // Make sure we are running before the saturation sweep
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Saturation: more than 65535 accepted redirects
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
        idle(1);
        chk("taken_sat", 32'(taken_count), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
